// File: rtl/sram_fifo_controller_if.sv
// Bundles the requester-side and SRAM-side signals of the SRAM FIFO controller.
// The slave modport is the controller itself; the master modport is everything
// around it: the producer/consumer pair plus the SRAM, which returns read data.
interface sram_fifo_controller_if #(
    parameter int nrOfAddressBits = 5,
    parameter int nrOfDataBits    = 32
);
    logic                       flush;
    logic                       push;
    logic [nrOfDataBits-1:0]    pushData;
    logic                       pop;
    logic [nrOfDataBits-1:0]    popData;
    logic                       full;
    logic                       empty;
    logic [nrOfAddressBits:0]   count;
    logic                       overflow;
    logic                       underflow;
    logic                       sramWe;
    logic [nrOfAddressBits-1:0] sramWrAddr;
    logic [nrOfAddressBits-1:0] sramRdAddr;
    logic [nrOfDataBits-1:0]    sramWrData;
    logic [nrOfDataBits-1:0]    sramRdData;

    modport master (
        output flush, push, pushData, pop, sramRdData,
        input  popData, full, empty, count, overflow, underflow,
        input  sramWe, sramWrAddr, sramRdAddr, sramWrData
    );

    modport slave (
        input  flush, push, pushData, pop, sramRdData,
        output popData, full, empty, count, overflow, underflow,
        output sramWe, sramWrAddr, sramRdAddr, sramWrData
    );
endinterface

// File: rtl/sram_fifo_controller.sv
// First-word-fall-through FIFO built around one simple-dual-port synchronous SRAM
// with a registered read port. The controller owns the pointers, occupancy count
// and flags, and forwards freshly written data when the SRAM would return a stale
// word because the write and read addresses collide on the same edge.
module sram_fifo_controller #(
    parameter int nrOfAddressBits = 5,
    parameter int nrOfDataBits    = 32
) (
    input  logic                 clock,
    input  logic                 nReset,
    sram_fifo_controller_if.slave bus
);
    localparam int A = nrOfAddressBits;
    localparam logic [A:0] depth = {1'b1, {A{1'b0}}};

    logic [A:0]              r_wrPtr;
    logic [A:0]              r_rdPtr;
    logic [A:0]              r_count;
    logic                    r_bypassValid;
    logic [nrOfDataBits-1:0] r_bypassReg;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_pushAcc;
    logic                    w_popAcc;
    logic                    w_collision;
    logic [A-1:0]            w_wrAddr;
    logic [A-1:0]            w_rdAddr;

    // Flags come only from the registered count, so accept decisions use pre-edge state.
    // Nothing is accepted while flushing or held in reset, so the SRAM is never written then.
    assign w_full      = (r_count == depth);
    assign w_empty     = (r_count == '0);
    assign w_pushAcc   = nReset & ~bus.flush & bus.push & ~w_full;
    assign w_popAcc    = nReset & ~bus.flush & bus.pop & ~w_empty;
    assign w_wrAddr    = r_wrPtr[A-1:0];
    assign w_rdAddr    = w_popAcc ? (r_rdPtr[A-1:0] + A'(1)) : r_rdPtr[A-1:0];
    assign w_collision = w_pushAcc & (w_wrAddr == w_rdAddr);

    assign bus.sramWe     = w_pushAcc;
    assign bus.sramWrAddr = w_wrAddr;
    assign bus.sramWrData = bus.pushData;
    assign bus.sramRdAddr = w_rdAddr;
    assign bus.popData    = r_bypassValid ? r_bypassReg : bus.sramRdData;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;

    // Pointer, occupancy, bypass and sticky-error state; reset beats flush beats traffic.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_bypassValid <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (bus.flush) begin
            r_rdPtr       <= r_wrPtr;
            r_count       <= '0;
            r_bypassValid <= 1'b0;
        end else begin
            if (w_pushAcc) begin
                r_wrPtr <= r_wrPtr + (A+1)'(1);
            end
            if (w_popAcc) begin
                r_rdPtr <= r_rdPtr + (A+1)'(1);
            end
            case ({w_pushAcc, w_popAcc})
                2'b10:   r_count <= r_count + (A+1)'(1);
                2'b01:   r_count <= r_count - (A+1)'(1);
                default: r_count <= r_count;
            endcase
            r_bypassValid <= w_collision;
            r_overflow    <= r_overflow | (bus.push & w_full);
            r_underflow   <= r_underflow | (bus.pop & w_empty);
        end
    end

    // Capture the word being written when the SRAM read would miss it this edge.
    always_ff @(posedge clock) begin
        if (w_collision) begin
            r_bypassReg <= bus.pushData;
        end
    end
endmodule
